// File: rtl/ccd_sequencer_if.sv
// Link between the frame sequencer, the CCD readout engine and the downstream
// pixel stream. The master side is the sequencer.
interface ccd_sequencer_if;
  // Engine control and data
  logic        ccd_toggle;
  logic [1:0]  ccd_mode;
  logic        ccd_busy;
  logic [15:0] ccd_data;
  logic        ccd_data_avail;
  logic        ccd_data_accept;
  // Downstream ready/valid pixel stream
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output ccd_toggle, ccd_mode, ccd_data_accept, pix_data, pix_valid,
    input  ccd_busy, ccd_data, ccd_data_avail, pix_ready
  );

  modport slave (
    input  ccd_toggle, ccd_mode, ccd_data_accept, pix_data, pix_valid,
    output ccd_busy, ccd_data, ccd_data_avail, pix_ready
  );
endinterface

// File: rtl/ccd_sequencer.sv
// Frame-level acquisition controller: N clean passes, a timed exposure, then
// one readout pass, forwarding each engine pixel word to a ready/valid stream.
module ccd_sequencer #(
  parameter int TICK_DIV = 48000,
  parameter int EXP_W    = 24,
  parameter int CNT_W    = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           n_flush,
  input  logic [EXP_W-1:0]     exp_ticks,
  input  logic                 bin2x2,
  ccd_sequencer_if.master      ccd,
  output logic                 seq_busy,
  output logic                 shutter,
  output logic                 frame_done,
  output logic                 aborted,
  output logic [CNT_W-1:0]     pix_count
);

  // Engine mode codes
  localparam logic [1:0] ccd_mode_idle        = 2'd0;
  localparam logic [1:0] ccd_mode_clean       = 2'd1;
  localparam logic [1:0] ccd_mode_readout_1x1 = 2'd2;
  localparam logic [1:0] ccd_mode_readout_2x2 = 2'd3;

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FL_KICK, S_FL_WAIT, S_EXPOSE, S_RD_KICK, S_RD_WAIT, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [3:0]        n_flush_q, flush_cnt;
  logic [EXP_W-1:0]  exp_q, tick_cnt;
  logic [PRE_W-1:0]  presc;
  logic              bin_q;
  logic              avail_q, avail_qq;
  logic [15:0]       pix_data_q;
  logic              pix_valid_q;

  logic start_ok, stop_req, tick_wrap, exp_last, flush_more, capture, xfer;
  logic in_run;

  // Decode of events shared by the FSM and the datapath
  always_comb begin
    start_ok   = (state == S_IDLE) && start && !abort;
    stop_req   = aborted || abort;
    tick_wrap  = (presc == PRE_W'(TICK_DIV - 1));
    exp_last   = tick_wrap && (tick_cnt == exp_q - 1'b1);
    flush_more = ({1'b0, flush_cnt} + 5'd1) < {1'b0, n_flush_q};
    xfer       = pix_valid_q && ccd.pix_ready;
    capture    = (state == S_RD_WAIT) && !stop_req && !pix_valid_q && avail_q && !avail_qq;
    in_run     = (state != S_IDLE) && (state != S_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
    state_d             = state;
    ccd.ccd_toggle      = 1'b0;
    ccd.ccd_mode        = ccd_mode_idle;
    ccd.ccd_data_accept = !pix_valid_q;
    ccd.pix_data        = pix_data_q;
    ccd.pix_valid       = pix_valid_q;
    seq_busy            = (state != S_IDLE);
    shutter             = (state == S_EXPOSE);
    frame_done          = (state == S_DONE);

    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (n_flush != 4'd0)          state_d = S_FL_KICK;
          else if (exp_ticks != '0)     state_d = S_EXPOSE;
          else                          state_d = S_RD_KICK;
        end
      end
      S_FL_KICK: begin
        ccd.ccd_mode   = ccd_mode_clean;
        ccd.ccd_toggle = 1'b1;
        if (ccd.ccd_busy) state_d = S_FL_WAIT;
      end
      S_FL_WAIT: begin
        ccd.ccd_mode = ccd_mode_clean;
        if (!ccd.ccd_busy) begin
          if (stop_req)          state_d = S_DONE;
          else if (flush_more)   state_d = S_FL_KICK;
          else if (exp_q != '0)  state_d = S_EXPOSE;
          else                   state_d = S_RD_KICK;
        end
      end
      S_EXPOSE: begin
        if (abort)         state_d = S_DONE;
        else if (exp_last) state_d = S_RD_KICK;
      end
      S_RD_KICK: begin
        ccd.ccd_mode   = bin_q ? ccd_mode_readout_2x2 : ccd_mode_readout_1x1;
        ccd.ccd_toggle = 1'b1;
        if (ccd.ccd_busy) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        ccd.ccd_mode = bin_q ? ccd_mode_readout_2x2 : ccd_mode_readout_1x1;
        // The holder is emptied the cycle after an abort, so this also covers the drain path.
        if (!ccd.ccd_busy && !pix_valid_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Run parameters, counters, abort flag and the one-word pixel holder
  always_ff @(posedge clk) begin
    if (rst) begin
      n_flush_q   <= '0;
      exp_q       <= '0;
      bin_q       <= 1'b0;
      flush_cnt   <= '0;
      presc       <= '0;
      tick_cnt    <= '0;
      avail_q     <= 1'b0;
      avail_qq    <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_count   <= '0;
      aborted     <= 1'b0;
    end else begin
      avail_q  <= ccd.ccd_data_avail;
      avail_qq <= avail_q;

      if (start_ok) begin
        n_flush_q <= n_flush;
        exp_q     <= exp_ticks;
        bin_q     <= bin2x2;
        flush_cnt <= '0;
        pix_count <= '0;
        aborted   <= 1'b0;
      end

      if (in_run && abort) aborted <= 1'b1;

      if ((state == S_FL_WAIT) && !ccd.ccd_busy) flush_cnt <= flush_cnt + 4'd1;

      // Prescaler and tick counter only run while exposing; they restart from 0 on entry.
      if (state == S_EXPOSE) begin
        if (tick_wrap) begin
          presc    <= '0;
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        presc    <= '0;
        tick_cnt <= '0;
      end

      // After an abort during readout the held word is dropped and accept stays high.
      if (((state == S_RD_KICK) || (state == S_RD_WAIT)) && stop_req) begin
        pix_valid_q <= 1'b0;
      end else if (capture) begin
        pix_data_q  <= ccd.ccd_data;
        pix_valid_q <= 1'b1;
      end else if (xfer) begin
        pix_valid_q <= 1'b0;
      end

      if (xfer && (pix_count != '1)) pix_count <= pix_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ccd_sequencer.sv
// Directed bench for ccd_sequencer with a small behavioural readout engine.
module tb_ccd_sequencer;

  localparam int TICK_DIV = 4;
  localparam int EXP_W    = 24;
  localparam int CNT_W    = 22;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_CLEAN = 2'd1;
  localparam logic [1:0] MODE_RD1   = 2'd2;
  localparam logic [1:0] MODE_RD2   = 2'd3;

  localparam int NPIX_1X1 = 20;  // 5x4 test sensor
  localparam int NPIX_2X2 = 6;

  logic             clk = 1'b0;
  logic             rst, start, abort, bin2x2;
  logic [3:0]       n_flush;
  logic [EXP_W-1:0] exp_ticks;
  logic             seq_busy, shutter, frame_done, aborted;
  logic [CNT_W-1:0] pix_count;

  ccd_sequencer_if bus ();

  ccd_sequencer #(.TICK_DIV(TICK_DIV), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_flush    (n_flush),
    .exp_ticks  (exp_ticks),
    .bin2x2     (bin2x2),
    .ccd        (bus.master),
    .seq_busy   (seq_busy),
    .shutter    (shutter),
    .frame_done (frame_done),
    .aborted    (aborted),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Statistics gathered by the engine model and the monitor
  int   clean_tog, rd1_tog, rd2_tog;
  int   shut_cyc, done_pulses, fwd_cnt, data_bad, mode_viol, abort_viol;
  logic abort_arm = 1'b0;
  logic busy_at_done, aborted_at_done;

  task automatic clear_stats();
    clean_tog = 0; rd1_tog = 0; rd2_tog = 0;
    shut_cyc = 0; done_pulses = 0; fwd_cnt = 0; data_bad = 0;
    mode_viol = 0; abort_viol = 0;
    busy_at_done = 1'bx; aborted_at_done = 1'bx;
  endtask

  // Behavioural readout engine: each avail edge is 4 clk after the fall, and the
  // engine waits 4 clk after the rise before looking at accept (module_clk >= 4 clk).
  initial begin
    logic [1:0] eng_mode;
    int npix, stall;
    bus.ccd_busy       = 1'b0;
    bus.ccd_data_avail = 1'b1;
    bus.ccd_data       = 16'h0000;
    forever begin
      step();
      if (bus.ccd_toggle) begin
        eng_mode     = bus.ccd_mode;
        bus.ccd_busy = 1'b1;
        case (eng_mode)
          MODE_CLEAN: clean_tog++;
          MODE_RD1:   rd1_tog++;
          MODE_RD2:   rd2_tog++;
          default: ;
        endcase
        if ((eng_mode == MODE_RD1) || (eng_mode == MODE_RD2)) begin
          npix = (eng_mode == MODE_RD1) ? NPIX_1X1 : NPIX_2X2;
          for (int p = 0; p < npix; p++) begin
            bus.ccd_data_avail = 1'b0;
            repeat (4) step();
            bus.ccd_data       = 16'hA000 + 16'(p);
            bus.ccd_data_avail = 1'b1;
            repeat (4) step();
            stall = 0;
            while (!bus.ccd_data_accept && stall < 2000) begin
              step();
              stall++;
            end
          end
        end else begin
          repeat (6) step();
        end
        repeat (2) step();
        bus.ccd_busy = 1'b0;
      end
    end
  end

  // Monitor sampled on the falling edge
  initial begin
    logic       prev_busy;
    logic [1:0] prev_mode;
    prev_busy = 1'b0;
    prev_mode = MODE_IDLE;
    forever begin
      @(negedge clk);
      if (shutter === 1'b1) shut_cyc++;
      if (frame_done === 1'b1) begin
        done_pulses++;
        busy_at_done    = bus.ccd_busy;
        aborted_at_done = aborted;
      end
      if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
        if (bus.pix_data !== 16'hA000 + 16'(fwd_cnt)) data_bad++;
        fwd_cnt++;
      end
      if (bus.ccd_busy && prev_busy && (bus.ccd_mode !== prev_mode)) mode_viol++;
      if (abort_arm && (bus.pix_valid !== 1'b0 || bus.ccd_data_accept !== 1'b1)) abort_viol++;
      prev_busy = bus.ccd_busy;
      prev_mode = bus.ccd_mode;
    end
  end

  task automatic do_start(input logic [3:0] nf, input logic [EXP_W-1:0] et, input logic b2);
    n_flush   = nf;
    exp_ticks = et;
    bin2x2    = b2;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (done_pulses == 0 && i < budget) begin
      step();
      i++;
    end
    check({tag, "_done_seen"}, 32'(done_pulses != 0), 32'd1);
    step();
  endtask

  task automatic wait_engine_idle(input string tag);
    int i = 0;
    while (bus.ccd_busy && i < 2000) begin
      step();
      i++;
    end
    check({tag, "_engine_idle"}, 32'(bus.ccd_busy), 32'd0);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_toggle"},   32'(bus.ccd_toggle),      32'd0);
    check({tag, "_mode"},     32'(bus.ccd_mode),        32'(MODE_IDLE));
    check({tag, "_accept"},   32'(bus.ccd_data_accept), 32'd1);
    check({tag, "_valid"},    32'(bus.pix_valid),       32'd0);
    check({tag, "_data"},     32'(bus.pix_data),        32'd0);
    check({tag, "_seq_busy"}, 32'(seq_busy),            32'd0);
    check({tag, "_shutter"},  32'(shutter),             32'd0);
    check({tag, "_done"},     32'(frame_done),          32'd0);
    check({tag, "_aborted"},  32'(aborted),             32'd0);
    check({tag, "_count"},    32'(pix_count),           32'd0);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int bad, i;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    n_flush = '0; exp_ticks = '0; bin2x2 = 1'b0;
    bus.pix_ready = 1'b1;
    clear_stats();
    repeat (3) step();
    check_reset_values("rst");
    rst = 1'b0;
    step();

    // 1: two clean passes, 3-tick exposure, 1x1 readout of 20 words
    clear_stats();
    do_start(4'd2, 24'd3, 1'b0);
    wait_done("t1", 3000);
    check("t1_clean_tog", 32'(clean_tog),   32'd2);
    check("t1_rd1_tog",   32'(rd1_tog),     32'd1);
    check("t1_rd2_tog",   32'(rd2_tog),     32'd0);
    check("t1_shutter",   32'(shut_cyc),    32'd12);
    check("t1_fwd",       32'(fwd_cnt),     32'd20);
    check("t1_pix_count", 32'(pix_count),   32'd20);
    check("t1_data",      32'(data_bad),    32'd0);
    check("t1_done_cnt",  32'(done_pulses), 32'd1);
    check("t1_mode_busy", 32'(mode_viol),   32'd0);
    check("t1_aborted",   32'(aborted),     32'd0);
    check("t1_idle",      32'(seq_busy),    32'd0);
    wait_engine_idle("t1");

    // 2: no flush, no exposure, 2x2 readout goes straight to RD_KICK
    clear_stats();
    do_start(4'd0, 24'd0, 1'b1);
    check("t2_kick_toggle", 32'(bus.ccd_toggle), 32'd1);
    check("t2_kick_mode",   32'(bus.ccd_mode),   32'(MODE_RD2));
    wait_done("t2", 2000);
    check("t2_clean_tog",  32'(clean_tog), 32'd0);
    check("t2_rd2_tog",    32'(rd2_tog),   32'd1);
    check("t2_shutter",    32'(shut_cyc),  32'd0);
    check("t2_fwd",        32'(fwd_cnt),   32'd6);
    check("t2_pix_count",  32'(pix_count), 32'd6);
    check("t2_data",       32'(data_bad),  32'd0);
    wait_engine_idle("t2");

    // 3: downstream stall for 50 cycles on the first word
    clear_stats();
    bus.pix_ready = 1'b0;
    do_start(4'd0, 24'd1, 1'b0);
    i = 0;
    while (!bus.pix_valid && i < 500) begin
      step();
      i++;
    end
    check("t3_valid_seen", 32'(bus.pix_valid), 32'd1);
    held = bus.pix_data;
    check("t3_first_word", 32'(held), 32'hA000);
    bad = 0;
    repeat (50) begin
      step();
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== held ||
          bus.ccd_data_accept !== 1'b0 || bus.ccd_busy !== 1'b1) bad++;
    end
    check("t3_stall_hold", 32'(bad), 32'd0);
    check("t3_no_fwd",     32'(fwd_cnt), 32'd0);
    bus.pix_ready = 1'b1;
    step();
    check("t3_release_accept", 32'(bus.ccd_data_accept), 32'd1);
    check("t3_release_count",  32'(pix_count),           32'd1);
    wait_done("t3", 3000);
    check("t3_fwd",       32'(fwd_cnt),   32'd20);
    check("t3_pix_count", 32'(pix_count), 32'd20);
    check("t3_data",      32'(data_bad),  32'd0);
    wait_engine_idle("t3");

    // 4: abort at tick 1 of a 10-tick exposure
    clear_stats();
    do_start(4'd0, 24'd10, 1'b0);
    repeat (TICK_DIV) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_done_next", 32'(frame_done), 32'd1);
    check("t4_shutter",   32'(shutter),    32'd0);
    check("t4_aborted",   32'(aborted),    32'd1);
    check("t4_shut_cyc",  32'(shut_cyc),   32'd5);
    step();
    check("t4_idle",        32'(seq_busy),          32'd0);
    check("t4_pulse_once",  32'(frame_done),        32'd0);
    check("t4_sticky",      32'(aborted),           32'd1);
    check("t4_no_readout",  32'(rd1_tog + rd2_tog), 32'd0);

    // 5: abort in the middle of a 1x1 readout
    clear_stats();
    do_start(4'd0, 24'd0, 1'b0);
    i = 0;
    while (fwd_cnt < 3 && i < 1000) begin
      step();
      i++;
    end
    check("t5_words_before", 32'(fwd_cnt >= 3), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    abort_arm = 1'b1;
    wait_done("t5", 3000);
    abort_arm = 1'b0;
    check("t5_drain",        32'(abort_viol),      32'd0);
    check("t5_busy_at_done", 32'(busy_at_done),    32'd0);
    check("t5_abort_flag",   32'(aborted_at_done), 32'd1);
    check("t5_fwd_stopped",  32'(fwd_cnt < 20),    32'd1);
    check("t5_count_match",  32'(pix_count),       32'(fwd_cnt));
    wait_engine_idle("t5");

    // start together with abort in IDLE starts nothing and leaves aborted set
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("t5b_no_run",  32'(seq_busy), 32'd0);
    check("t5b_sticky",  32'(aborted),  32'd1);

    // 6: reset during FL_WAIT
    clear_stats();
    do_start(4'd3, 24'd2, 1'b0);
    i = 0;
    while (!(bus.ccd_busy && !bus.ccd_toggle && seq_busy) && i < 200) begin
      step();
      i++;
    end
    check("t6_in_fl_wait", 32'(bus.ccd_mode), 32'(MODE_CLEAN));
    rst = 1'b1;
    step();
    check_reset_values("t6_rst");
    rst = 1'b0;
    wait_engine_idle("t6");

    // start pulsed during EXPOSE is ignored
    clear_stats();
    do_start(4'd0, 24'd3, 1'b0);
    step();
    step();
    n_flush = 4'd5; exp_ticks = 24'd9; bin2x2 = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t6b", 3000);
    check("t6b_shutter",   32'(shut_cyc),  32'd12);
    check("t6b_clean_tog", 32'(clean_tog), 32'd0);
    check("t6b_rd1_tog",   32'(rd1_tog),   32'd1);
    check("t6b_rd2_tog",   32'(rd2_tog),   32'd0);
    check("t6b_fwd",       32'(fwd_cnt),   32'd20);
    check("t6b_aborted",   32'(aborted),   32'd0);
    check("t6b_done_cnt",  32'(done_pulses), 32'd1);
    wait_engine_idle("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccd_sequencer.md
Name: ccd_sequencer

Overview:
Frame-level controller for the CCD readout engine. One `start` runs a complete acquisition: N flush passes (clean mode), a timed exposure, then one readout pass in 1x1 or 2x2 mode. It forwards each pixel word from the readout engine to a downstream ready/valid stream, and applies backpressure through the engine's accept input. It sits between the host command decoder and the readout engine; it is the only driver of the engine's toggle, mode and accept inputs.

Parameters:
TICK_DIV, 48000, clk cycles per exposure tick (1 ms at 48 MHz)
EXP_W, 24, width of exposure time in ticks
CNT_W, 22, width of forwarded-pixel counter

Ports:
clk  in  1  system clock; all signals synchronous to it
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin acquisition (ignored unless IDLE)
abort  in  1  one-cycle pulse; terminate acquisition early
n_flush  in  4  number of clean passes, sampled at start
exp_ticks  in  EXP_W  exposure length in ticks, sampled at start
bin2x2  in  1  0 = readout_1x1, 1 = readout_2x2, sampled at start
ccd_toggle  out  1  to engine toggle
ccd_mode  out  2  to engine mode (codes ccd_mode_* from ccd_readout.vh)
ccd_busy  in  1  from engine busy
ccd_data  in  16  from engine data_out
ccd_data_avail  in  1  from engine data_avail
ccd_data_accept  out  1  to engine data_accept
pix_data  out  16  pixel word to downstream
pix_valid  out  1  pix_data valid
pix_ready  in  1  downstream accepts when pix_valid && pix_ready
seq_busy  out  1  high in every state except IDLE
shutter  out  1  high only in EXPOSE
frame_done  out  1  one-cycle pulse on entering DONE
aborted  out  1  sticky; set by abort during a run, cleared by next accepted start
pix_count  out  CNT_W  words forwarded in current frame; cleared at start

Behaviour:
- Reset: state IDLE. ccd_toggle=0, ccd_mode=ccd_mode_idle, ccd_data_accept=1, pix_valid=0, pix_data=0, seq_busy=0, shutter=0, frame_done=0, aborted=0, pix_count=0, internal counters 0.
- States: IDLE, FL_KICK, FL_WAIT, EXPOSE, RD_KICK, RD_WAIT, DONE.
- IDLE + start (and no abort in the same cycle): latch n_flush, exp_ticks and bin2x2; clear pix_count and aborted; flush_cnt=0. Next state:
  - FL_KICK if n_flush>0;
  - else EXPOSE if exp_ticks>0;
  - else RD_KICK.
  - start and abort in the same cycle in IDLE: no run starts.
- FL_KICK: ccd_mode=ccd_mode_clean, ccd_toggle=1. Hold both until ccd_busy=1, then go to FL_WAIT with ccd_toggle=0.
- FL_WAIT: mode stays clean until ccd_busy=0. Then flush_cnt+1; if flush_cnt<n_flush go to FL_KICK, else go to EXPOSE or RD_KICK per the exp_ticks rule above.
- ccd_mode changes only in *_KICK states or on entering IDLE/DONE; it never changes while ccd_busy=1.
- EXPOSE: ccd_mode=idle, shutter=1. Prescaler counts to TICK_DIV-1, then tick_cnt+1. After exactly exp_ticks*TICK_DIV cycles, go to RD_KICK.
- RD_KICK/RD_WAIT: as the flush states, but with mode readout_1x1 or readout_2x2. RD_WAIT ends when ccd_busy=0 and no word is held; then go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE with ccd_mode=idle.
- Pixel capture (RD_WAIT only):
  - ccd_data_avail is registered once. A rising edge while the holder is empty latches ccd_data into pix_data, sets pix_valid=1, and drops ccd_data_accept to 0 on the same cycle (2 clk after the avail edge).
  - When pix_valid && pix_ready: pix_valid=0, ccd_data_accept=1, pix_count+1.
  - ccd_data_accept=1 whenever the holder is empty, including all non-readout states.
  - Clean mode forces avail high, so no edges occur and nothing is captured.
- Timing requirement: the engine's module_clk period is ≥4 clk periods, so accept is low before the engine samples it.
- pix_count saturates at its maximum value; it does not wrap.
- Abort handling:
  - Abort in EXPOSE: set aborted, go to DONE immediately, shutter=0.
  - Abort in FL_*/RD_*: set aborted. The engine cannot be stopped, so the current pass runs to ccd_busy=0. During RD_WAIT, pix_valid is forced 0, any held word is dropped, and ccd_data_accept is held 1 (drain). No further phases run; go to DONE.
  - Abort in IDLE/DONE: ignored.
- start outside IDLE is ignored. rst mid-run returns to the reset values at once; the engine finishes its pass unaided.

Test Plan:
- TICK_DIV=4, n_flush=2, exp_ticks=3, bin2x2=0, pix_ready=1, test engine 5x4 → two clean toggles, shutter high exactly 12 cycles, one readout_1x1 toggle, every avail edge forwarded, pix_count equals the forwarded word count, one frame_done pulse.
- n_flush=0, exp_ticks=0 → start goes straight to RD_KICK; shutter never asserts.
- pix_ready held 0 for 50 cycles after the first word → pix_valid stays 1 with pix_data stable, ccd_data_accept=0, engine stalls in h3; release → transfer completes, accept=1.
- Abort at tick 1 of a 10-tick exposure → DONE the next cycle, aborted=1, no readout toggle.
- Abort mid-readout → pix_valid=0 thereafter, ccd_data_accept=1 until ccd_busy=0, then frame_done with aborted=1.
- rst asserted during FL_WAIT → all outputs at reset values the next cycle; start pulsed in EXPOSE → ignored.
